// File: rtl/key_conditioner.sv
// rtl/key_conditioner.sv - synchronises, debounces and edge-detects active-low push keys
// Produces a clean level plus one-cycle press, release and long-hold pulses per key.
module key_conditioner #(
  parameter int N_KEYS          = 4,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int HOLD_CYCLES     = 50000000
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic [N_KEYS-1:0] key_n_i,
  output logic [N_KEYS-1:0] level_o,
  output logic [N_KEYS-1:0] press_o,
  output logic [N_KEYS-1:0] release_o,
  output logic [N_KEYS-1:0] hold_o
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES);
  localparam int HW = $clog2(HOLD_CYCLES + 1);
  localparam logic [DW-1:0] DLAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] HLAST = HW'(HOLD_CYCLES - 1);
  localparam logic [HW-1:0] HMAX  = HW'(HOLD_CYCLES);

  logic [N_KEYS-1:0] s1_q, s2_q;
  logic [N_KEYS-1:0] level_q, level_d;
  logic [N_KEYS-1:0] press_q, press_d;
  logic [N_KEYS-1:0] release_q, release_d;
  logic [N_KEYS-1:0] hold_q, hold_d;
  logic [DW-1:0]     dcnt_q [N_KEYS];
  logic [DW-1:0]     dcnt_d [N_KEYS];
  logic [HW-1:0]     hcnt_q [N_KEYS];
  logic [HW-1:0]     hcnt_d [N_KEYS];

  always_comb begin
    level_d   = level_q;
    press_d   = '0;
    release_d = '0;
    hold_d    = '0;
    for (int i = 0; i < N_KEYS; i++) begin
      dcnt_d[i] = dcnt_q[i];
      hcnt_d[i] = hcnt_q[i];

      // A single sample agreeing with the accepted level throws away the run.
      if (s2_q[i] == level_q[i]) begin
        dcnt_d[i] = '0;
      end else if (dcnt_q[i] == DLAST) begin
        level_d[i]   = s2_q[i];
        dcnt_d[i]    = '0;
        press_d[i]   = s2_q[i];
        release_d[i] = ~s2_q[i];
      end else begin
        dcnt_d[i] = dcnt_q[i] + 1'b1;
      end

      // Saturating at HMAX is what keeps hold to one pulse per press.
      if (!level_q[i]) begin
        hcnt_d[i] = '0;
      end else if (hcnt_q[i] < HMAX) begin
        hcnt_d[i] = hcnt_q[i] + 1'b1;
        hold_d[i] = (hcnt_q[i] == HLAST);
      end
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      s1_q      <= '0;
      s2_q      <= '0;
      level_q   <= '0;
      press_q   <= '0;
      release_q <= '0;
      hold_q    <= '0;
      dcnt_q    <= '{default: '0};
      hcnt_q    <= '{default: '0};
    end else begin
      s1_q      <= ~key_n_i;
      s2_q      <= s1_q;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      hold_q    <= hold_d;
      dcnt_q    <= dcnt_d;
      hcnt_q    <= hcnt_d;
    end
  end

  assign level_o   = level_q;
  assign press_o   = press_q;
  assign release_o = release_q;
  assign hold_o    = hold_q;

endmodule

// File: tb/tb_key_conditioner.sv
// tb/tb_key_conditioner.sv - table-driven scoreboard bench for key_conditioner
// Each row gives one key's raw press window and the edges where its level/pulses must appear.
module tb_key_conditioner;

  localparam int NK   = 4;
  localparam int DEB  = 4;
  localparam int HOLD = 10;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [NK-1:0] key_n = '1;
  logic [NK-1:0] level, press, rel, hold;

  always #5 clk = ~clk;

  key_conditioner #(
    .N_KEYS(NK), .DEBOUNCE_CYCLES(DEB), .HOLD_CYCLES(HOLD)
  ) dut (
    .clk_i(clk), .reset_i(reset), .key_n_i(key_n),
    .level_o(level), .press_o(press), .release_o(rel), .hold_o(hold)
  );

  typedef struct {
    int          seg;
    int          key;
    logic [63:0] raw;
    int          rise;
    int          fall;
    int          hold;
  } row_t;

  typedef struct {
    int            en;
    logic [NK-1:0] level;
    logic [NK-1:0] press;
    logic [NK-1:0] rel;
    logic [NK-1:0] hold;
  } exp_t;

  row_t rows[$];
  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic logic [63:0] span(input int a, input int b);
    logic [63:0] m;
    m = '0;
    for (int i = a; i < b; i++) m[i] = 1'b1;
    return m;
  endfunction

  function automatic row_t mk(input int s, input int k, input logic [63:0] r,
                              input int ri, input int fa, input int ho);
    row_t x;
    x.seg = s; x.key = k; x.raw = r; x.rise = ri; x.fall = fa; x.hold = ho;
    return x;
  endfunction

  task automatic check(input string name, input int en, input logic [NK-1:0] act,
                       input logic [NK-1:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s edge %0d: got %b want %b", name, en, act, want);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_level"}, 0, level, '0);
    check({tag, "_press"}, 0, press, '0);
    check({tag, "_release"}, 0, rel, '0);
    check({tag, "_hold"}, 0, hold, '0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    key_n = '1;
    #1;
    check_idle("reset");
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Called at a falling edge; edge 1 is the next rising edge.
  task automatic run_segment(input int s, input int stop);
    for (int e = 1; e <= stop; e++) begin
      logic [NK-1:0] kn;
      exp_t          x;
      exp_t          got;
      kn = '1;
      x.en = e; x.level = '0; x.press = '0; x.rel = '0; x.hold = '0;
      foreach (rows[j]) begin
        if (rows[j].seg == s) begin
          if (rows[j].raw[e]) kn[rows[j].key] = 1'b0;
          if (rows[j].rise != 0 && e >= rows[j].rise && (rows[j].fall == 0 || e < rows[j].fall))
            x.level[rows[j].key] = 1'b1;
          if (e == rows[j].rise) x.press[rows[j].key] = 1'b1;
          if (e == rows[j].fall) x.rel[rows[j].key]   = 1'b1;
          if (e == rows[j].hold) x.hold[rows[j].key]  = 1'b1;
        end
      end
      key_n = kn;
      sb.push_back(x);
      @(posedge clk);
      #1;
      got = sb.pop_front();
      check($sformatf("seg%0d_level", s), got.en, level, got.level);
      check($sformatf("seg%0d_press", s), got.en, press, got.press);
      check($sformatf("seg%0d_release", s), got.en, rel, got.rel);
      check($sformatf("seg%0d_hold", s), got.en, hold, got.hold);
      @(negedge clk);
    end
  endtask

  initial begin
    // seg 0: short press, sub-threshold bounce, full hold, press ending just before hold
    rows.push_back(mk(0, 0, span(1, 8),  6, 13, 0));
    rows.push_back(mk(0, 1, span(1, 4) | span(5, 8), 0, 0, 0));
    rows.push_back(mk(0, 2, span(1, 26), 6, 31, 16));
    rows.push_back(mk(0, 3, span(1, 10), 6, 15, 0));
    // seg 1: all keys fall together
    for (int k = 0; k < NK; k++) rows.push_back(mk(1, k, span(1, 9), 6, 14, 0));
    // seg 2: bounce before a long press; 2-cycle release glitch inside a hold
    rows.push_back(mk(2, 1, span(1, 4) | span(5, 21), 10, 26, 20));
    rows.push_back(mk(2, 0, span(1, 16) | span(18, 31), 6, 36, 16));
    // seg 3: key 0 held throughout, used around an asynchronous reset
    rows.push_back(mk(3, 0, span(1, 40), 6, 0, 16));

    do_reset();
    run_segment(0, 36);
    do_reset();
    run_segment(1, 20);
    do_reset();
    run_segment(2, 40);

    do_reset();
    run_segment(3, 11);
    reset = 1'b1;
    #1;
    check_idle("async_reset");
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    run_segment(3, 22);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
